axi_rd_arbiter_2m1s: RTL and testbench
======================================

Name: axi_rd_arbiter_2m1s

Overview:
- Shares the single AXI-full memory port between two read masters: m0 = instruction fetch, m1 = load/store unit (mem read/write stage).
- Also carries the m1 write channels straight through, and blocks m1 reads while an m1 write is outstanding.
- Sits between the IFU/LSU bus logic and the top-level AXI slave interface.
- Grants one read burst at a time and holds the grant from the AR handshake until the R beat with rlast.

Parameters:
- ADDR_W, 32, address width for all AR/AW channels.
- DATA_W, 64, data width for R/W channels; strobe width is DATA_W/8.
- RR_EN, 1, 1 = round-robin on ties; 0 = m1 always wins ties.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- m0_araddr/m0_arlen/m0_arsize/m0_arburst  input  ADDR_W/8/3/2  m0 read address channel payload.
- m0_arvalid  input  1 ; m0_arready  output  1  m0 AR handshake.
- m0_rdata/m0_rresp/m0_rlast  output  DATA_W/2/1  m0 read data channel payload.
- m0_rvalid  output  1 ; m0_rready  input  1  m0 R handshake.
- m1_araddr/m1_arlen/m1_arsize/m1_arburst  input  ADDR_W/8/3/2  m1 read address channel payload.
- m1_arvalid  input  1 ; m1_arready  output  1  m1 AR handshake.
- m1_rdata/m1_rresp/m1_rlast  output  DATA_W/2/1  m1 read data channel payload.
- m1_rvalid  output  1 ; m1_rready  input  1  m1 R handshake.
- m1_awaddr/m1_awlen/m1_awburst, m1_awvalid  input ; m1_awready  output  m1 write address channel, passed through.
- m1_wdata/m1_wstrb/m1_wlast/m1_wvalid  input ; m1_wready  output  m1 write data channel, passed through.
- m1_bresp/m1_bvalid  output ; m1_bready  input  m1 write response channel, passed through.
- s_ar*/s_r*/s_aw*/s_w*/s_b*  mirrored  slave-side copies of all of the above, directions reversed.
- rd_owner  output  1  0 = m0, 1 = m1; valid while rd_busy = 1.
- rd_busy  output  1  a read grant is active.
- proto_err  output  1  sticky flag: a read burst had a beat count that did not match its arlen.

Behaviour:
- Reset: asserting rst_n low clears all of the following immediately, independent of clk:
  - read state goes to R_IDLE; rd_busy = 0, rd_owner = 0, proto_err = 0;
  - wr_busy = 0, beat_cnt = 0, last_grant = 1 (so m0 wins the first tie);
  - every valid/ready output is 0.
  - Reset mid-burst abandons the burst; the slave is reset by the same net.
- Read state machine:
  - R_IDLE → R_AR when an eligible request exists.
    - Eligible: m0_arvalid, or (m1_arvalid and wr_busy = 0).
    - Tie, RR_EN = 1: grant the master that is not last_grant. RR_EN = 0: grant m1.
    - On the transition, latch owner, arlen_q and the selected AR payload, and set last_grant.
  - R_AR: s_arvalid = 1 carrying the latched payload; owner's arready = s_arready.
    - On s_arvalid & s_arready → R_DATA, beat_cnt = 0.
  - R_DATA: s_rready = owner's rready; owner's rvalid/rdata/rresp/rlast = s_r*. The non-owner sees rvalid = 0.
    - Each R handshake increments beat_cnt (8-bit, wraps).
    - On a handshake with s_rlast → R_IDLE.
    - If beat_cnt != arlen_q at that beat, set proto_err.
  - Non-owner arready = 0 at all times. In R_IDLE every arready = 0.
- Latency:
  - arvalid at cycle t → s_arvalid at t+1 at the earliest.
  - The back-to-back turnaround after rlast is 1 idle cycle (R_IDLE).
- Masters hold arvalid and the AR payload stable until arready (AXI rule). The arbiter never retracts s_arvalid before s_arready.
- Write path:
  - m1 AW/W/B are combinational pass-throughs.
  - wr_busy sets on the s_awvalid & s_awready handshake and clears on the s_bvalid & s_bready handshake. Set and clear in the same cycle leaves wr_busy = 1 (a new AW is accepted).
  - While rd_owner = 1 and rd_busy = 1, s_awvalid is masked to 0 and m1_awready = 0.
- Simultaneous m1_arvalid and m1_awvalid in R_IDLE with wr_busy = 0: the read is granted first, and AW is masked until the read finishes.
- A slave error response (rresp != 0) is forwarded unchanged; it does not set proto_err.

Test Plan:
- m0 alone, arlen = 1, 2-beat burst, data 0x11 then 0x22 → s_araddr = m0_araddr one cycle after m0_arvalid; m0 receives both beats, rlast on beat 2; m1_rvalid stays 0.
- m0 and m1 both assert arvalid on the same cycle after reset, RR_EN = 1 → m0 granted first, m1 next. Repeat the tie → m0 is granted, because m1 held the previous grant.
- RR_EN = 0, tie repeated 3 times → m1 granted every time.
- m1 write in flight (AW accepted, B not yet returned), m1_arvalid raised → m1_arready stays 0 until the B handshake; the grant happens the cycle after.
- Slave returns rlast on beat 1 while arlen = 3 → proto_err = 1 and stays 1 through later bursts; returns to 0 only on rst_n low.
- rst_n pulled low mid-R_DATA → rd_busy, s_arvalid and s_rready = 0 immediately; after release, a new m0 request is served normally.

Source files
------------

// File: rtl/axi_rd_arbiter_2m1s.sv
// Shares one AXI slave port between two read masters (m0 = IFU, m1 = LSU).
// m1 write channels pass through; m1 reads and writes are kept from overlapping.
module axi_rd_arbiter_2m1s #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64,
   parameter bit          RR_EN  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     m0_araddr,
   input  logic [7:0]            m0_arlen,
   input  logic [2:0]            m0_arsize,
   input  logic [1:0]            m0_arburst,
   input  logic                  m0_arvalid,
   output logic                  m0_arready,
   output logic [DATA_W-1:0]     m0_rdata,
   output logic [1:0]            m0_rresp,
   output logic                  m0_rlast,
   output logic                  m0_rvalid,
   input  logic                  m0_rready,
   input  logic [ADDR_W-1:0]     m1_araddr,
   input  logic [7:0]            m1_arlen,
   input  logic [2:0]            m1_arsize,
   input  logic [1:0]            m1_arburst,
   input  logic                  m1_arvalid,
   output logic                  m1_arready,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic [1:0]            m1_rresp,
   output logic                  m1_rlast,
   output logic                  m1_rvalid,
   input  logic                  m1_rready,
   input  logic [ADDR_W-1:0]     m1_awaddr,
   input  logic [7:0]            m1_awlen,
   input  logic [1:0]            m1_awburst,
   input  logic                  m1_awvalid,
   output logic                  m1_awready,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic [DATA_W/8-1:0]   m1_wstrb,
   input  logic                  m1_wlast,
   input  logic                  m1_wvalid,
   output logic                  m1_wready,
   output logic [1:0]            m1_bresp,
   output logic                  m1_bvalid,
   input  logic                  m1_bready,
   output logic [ADDR_W-1:0]     s_araddr,
   output logic [7:0]            s_arlen,
   output logic [2:0]            s_arsize,
   output logic [1:0]            s_arburst,
   output logic                  s_arvalid,
   input  logic                  s_arready,
   input  logic [DATA_W-1:0]     s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rlast,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   output logic [ADDR_W-1:0]     s_awaddr,
   output logic [7:0]            s_awlen,
   output logic [1:0]            s_awburst,
   output logic                  s_awvalid,
   input  logic                  s_awready,
   output logic [DATA_W-1:0]     s_wdata,
   output logic [DATA_W/8-1:0]   s_wstrb,
   output logic                  s_wlast,
   output logic                  s_wvalid,
   input  logic                  s_wready,
   input  logic [1:0]            s_bresp,
   input  logic                  s_bvalid,
   output logic                  s_bready,
   output logic                  rd_owner,
   output logic                  rd_busy,
   output logic                  proto_err
);

   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_AR   = 2'd1;
   localparam logic [1:0] R_DATA = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              wr_busy_q, wr_busy_d;
   logic              proto_err_q, proto_err_d;
   logic [7:0]        beat_cnt_q, beat_cnt_d;
   logic [7:0]        arlen_q, arlen_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [2:0]        arsize_q, arsize_d;
   logic [1:0]        arburst_q, arburst_d;

   logic m0_elig_c, m1_elig_c, grant_m1_c, aw_mask_c;
   logic r_hs_c, aw_hs_c, b_hs_c;

   // Arbitration: m1 is ineligible while its own write is outstanding
   always_comb begin
      m0_elig_c = m0_arvalid;
      m1_elig_c = m1_arvalid & ~wr_busy_q;
      if (m0_elig_c && m1_elig_c) grant_m1_c = RR_EN ? ~last_grant_q : 1'b1;
      else                        grant_m1_c = m1_elig_c;
   end

   // AW is held off during an m1 read, including the cycle that read is being granted
   assign aw_mask_c = ((state_q != R_IDLE) & owner_q)
                    | ((state_q == R_IDLE) & m1_elig_c & grant_m1_c);

   assign s_arvalid  = (state_q == R_AR);
   assign s_araddr   = araddr_q;
   assign s_arlen    = arlen_q;
   assign s_arsize   = arsize_q;
   assign s_arburst  = arburst_q;
   assign m0_arready = s_arvalid & ~owner_q & s_arready;
   assign m1_arready = s_arvalid &  owner_q & s_arready;

   assign s_rready  = (state_q == R_DATA) & (owner_q ? m1_rready : m0_rready);
   assign m0_rvalid = (state_q == R_DATA) & ~owner_q & s_rvalid;
   assign m1_rvalid = (state_q == R_DATA) &  owner_q & s_rvalid;
   assign m0_rdata  = s_rdata;
   assign m0_rresp  = s_rresp;
   assign m0_rlast  = s_rlast;
   assign m1_rdata  = s_rdata;
   assign m1_rresp  = s_rresp;
   assign m1_rlast  = s_rlast;
   assign r_hs_c    = s_rvalid & s_rready;

   assign s_awaddr   = m1_awaddr;
   assign s_awlen    = m1_awlen;
   assign s_awburst  = m1_awburst;
   assign s_awvalid  = m1_awvalid & ~aw_mask_c;
   assign m1_awready = s_awready & ~aw_mask_c;
   assign s_wdata    = m1_wdata;
   assign s_wstrb    = m1_wstrb;
   assign s_wlast    = m1_wlast;
   assign s_wvalid   = m1_wvalid;
   assign m1_wready  = s_wready;
   assign m1_bresp   = s_bresp;
   assign m1_bvalid  = s_bvalid;
   assign s_bready   = m1_bready;
   assign aw_hs_c    = s_awvalid & s_awready;
   assign b_hs_c     = s_bvalid & s_bready;

   assign rd_busy   = (state_q != R_IDLE);
   assign rd_owner  = owner_q;
   assign proto_err = proto_err_q;

   // Read FSM next state and latched burst context
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      arlen_d      = arlen_q;
      araddr_d     = araddr_q;
      arsize_d     = arsize_q;
      arburst_d    = arburst_q;
      proto_err_d  = proto_err_q;
      wr_busy_d    = aw_hs_c ? 1'b1 : (b_hs_c ? 1'b0 : wr_busy_q);
      case (state_q)
         R_IDLE: begin
            if (m0_elig_c || m1_elig_c) begin
               state_d      = R_AR;
               owner_d      = grant_m1_c;
               last_grant_d = grant_m1_c;
               if (grant_m1_c) begin
                  araddr_d  = m1_araddr;
                  arlen_d   = m1_arlen;
                  arsize_d  = m1_arsize;
                  arburst_d = m1_arburst;
               end else begin
                  araddr_d  = m0_araddr;
                  arlen_d   = m0_arlen;
                  arsize_d  = m0_arsize;
                  arburst_d = m0_arburst;
               end
            end
         end
         R_AR: begin
            if (s_arready) begin
               state_d    = R_DATA;
               beat_cnt_d = 8'd0;
            end
         end
         R_DATA: begin
            if (r_hs_c) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               if (s_rlast) begin
                  state_d = R_IDLE;
                  if (beat_cnt_q != arlen_q) proto_err_d = 1'b1;
               end
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= R_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         wr_busy_q    <= 1'b0;
         proto_err_q  <= 1'b0;
         beat_cnt_q   <= 8'd0;
         arlen_q      <= 8'd0;
         araddr_q     <= '0;
         arsize_q     <= 3'd0;
         arburst_q    <= 2'd0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         wr_busy_q    <= wr_busy_d;
         proto_err_q  <= proto_err_d;
         beat_cnt_q   <= beat_cnt_d;
         arlen_q      <= arlen_d;
         araddr_q     <= araddr_d;
         arsize_q     <= arsize_d;
         arburst_q    <= arburst_d;
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter_2m1s.sv
// Directed bench for axi_rd_arbiter_2m1s; a second instance with RR_EN = 0 shares all inputs.
module tb_axi_rd_arbiter_2m1s;

   logic clk;
   logic rst_n;
   logic [31:0] m0_araddr, m1_araddr, m1_awaddr;
   logic [7:0]  m0_arlen, m1_arlen, m1_awlen;
   logic [2:0]  m0_arsize, m1_arsize;
   logic [1:0]  m0_arburst, m1_arburst, m1_awburst;
   logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready, m1_awvalid;
   logic [63:0] m1_wdata, s_rdata;
   logic [7:0]  m1_wstrb;
   logic        m1_wlast, m1_wvalid, m1_bready;
   logic        s_arready, s_rlast, s_rvalid, s_awready, s_wready, s_bvalid;
   logic [1:0]  s_rresp, s_bresp;

   logic        m0_arready, m0_rlast, m0_rvalid, m1_arready, m1_rlast, m1_rvalid;
   logic [63:0] m0_rdata, m1_rdata, s_wdata;
   logic [1:0]  m0_rresp, m1_rresp, m1_bresp, s_arburst, s_awburst;
   logic        m1_awready, m1_wready, m1_bvalid;
   logic [31:0] s_araddr, s_awaddr;
   logic [7:0]  s_arlen, s_awlen, s_wstrb;
   logic [2:0]  s_arsize;
   logic        s_arvalid, s_rready, s_awvalid, s_wlast, s_wvalid, s_bready;
   logic        rd_owner, rd_busy, proto_err;

   logic        u1_m0_arready, u1_m0_rlast, u1_m0_rvalid, u1_m1_arready, u1_m1_rlast, u1_m1_rvalid;
   logic [63:0] u1_m0_rdata, u1_m1_rdata, u1_s_wdata;
   logic [1:0]  u1_m0_rresp, u1_m1_rresp, u1_m1_bresp, u1_s_arburst, u1_s_awburst;
   logic        u1_m1_awready, u1_m1_wready, u1_m1_bvalid;
   logic [31:0] u1_s_araddr, u1_s_awaddr;
   logic [7:0]  u1_s_arlen, u1_s_awlen, u1_s_wstrb;
   logic [2:0]  u1_s_arsize;
   logic        u1_s_arvalid, u1_s_rready, u1_s_awvalid, u1_s_wlast, u1_s_wvalid, u1_s_bready;
   logic        u1_rd_owner, u1_rd_busy, u1_proto_err;

   int total;
   int bad;

   axi_rd_arbiter_2m1s #(.ADDR_W(32), .DATA_W(64), .RR_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid),
      .m1_awready(m1_awready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid),
      .m1_bready(m1_bready),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awvalid(s_awvalid),
      .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
      .s_bready(s_bready),
      .rd_owner(rd_owner), .rd_busy(rd_busy), .proto_err(proto_err)
   );

   axi_rd_arbiter_2m1s #(.ADDR_W(32), .DATA_W(64), .RR_EN(1'b0)) u_dut_fixed (
      .clk(clk), .rst_n(rst_n),
      .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_arvalid(m0_arvalid), .m0_arready(u1_m0_arready), .m0_rdata(u1_m0_rdata), .m0_rresp(u1_m0_rresp),
      .m0_rlast(u1_m0_rlast), .m0_rvalid(u1_m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_arvalid(m1_arvalid), .m1_arready(u1_m1_arready), .m1_rdata(u1_m1_rdata), .m1_rresp(u1_m1_rresp),
      .m1_rlast(u1_m1_rlast), .m1_rvalid(u1_m1_rvalid), .m1_rready(m1_rready),
      .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awburst(m1_awburst), .m1_awvalid(m1_awvalid),
      .m1_awready(u1_m1_awready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
      .m1_wvalid(m1_wvalid), .m1_wready(u1_m1_wready), .m1_bresp(u1_m1_bresp), .m1_bvalid(u1_m1_bvalid),
      .m1_bready(m1_bready),
      .s_araddr(u1_s_araddr), .s_arlen(u1_s_arlen), .s_arsize(u1_s_arsize), .s_arburst(u1_s_arburst),
      .s_arvalid(u1_s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(u1_s_rready),
      .s_awaddr(u1_s_awaddr), .s_awlen(u1_s_awlen), .s_awburst(u1_s_awburst), .s_awvalid(u1_s_awvalid),
      .s_awready(s_awready), .s_wdata(u1_s_wdata), .s_wstrb(u1_s_wstrb), .s_wlast(u1_s_wlast),
      .s_wvalid(u1_s_wvalid), .s_wready(s_wready), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
      .s_bready(u1_s_bready),
      .rd_owner(u1_rd_owner), .rd_busy(u1_rd_busy), .proto_err(u1_proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Waits (bounded) for the AR phase, accepts it, and returns a single-beat rlast burst
   task automatic grant_cycle(input logic drop, output logic ok, output int waits,
                              output logic own0, output logic own1);
      ok = 1'b0; waits = 0; own0 = 1'b0; own1 = 1'b0;
      while (!ok && waits < 20) begin
         if (s_arvalid) ok = 1'b1;
         else begin tick(); waits++; end
      end
      if (ok) begin
         own0 = rd_owner;
         own1 = u1_rd_owner;
         s_arready = 1'b1;
         tick();
         s_arready = 1'b0;
         if (drop) begin
            if (own0) m1_arvalid = 1'b0;
            else      m0_arvalid = 1'b0;
         end
         s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'hA5;
         tick();
         s_rvalid = 1'b0; s_rlast = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++; if (rd_busy !== 1'b0) begin bad++; $display("FAIL reset_rd_busy got=%0b exp=0", rd_busy); end
      total++; if (rd_owner !== 1'b0) begin bad++; $display("FAIL reset_rd_owner got=%0b exp=0", rd_owner); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_proto_err got=%0b exp=0", proto_err); end
      total++; if ({s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 6'b0) begin
         bad++; $display("FAIL reset_handshakes got=%b exp=000000",
                         {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_m0_single();
      m0_araddr = 32'h0000_1000; m0_arlen = 8'd1; m0_arsize = 3'd3; m0_arburst = 2'd1;
      m0_arvalid = 1'b1;
      #1;
      total++; if (s_arvalid !== 1'b0) begin bad++; $display("FAIL single_ar_same_cycle got=%0b exp=0", s_arvalid); end
      tick();
      total++; if (s_arvalid !== 1'b1) begin bad++; $display("FAIL single_s_arvalid got=%0b exp=1", s_arvalid); end
      total++; if (s_araddr !== 32'h0000_1000) begin bad++; $display("FAIL single_s_araddr got=%h exp=00001000", s_araddr); end
      total++; if (s_arlen !== 8'd1) begin bad++; $display("FAIL single_s_arlen got=%0d exp=1", s_arlen); end
      total++; if (m0_arready !== 1'b0) begin bad++; $display("FAIL single_arready_wait got=%0b exp=0", m0_arready); end
      s_arready = 1'b1;
      #1;
      total++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0) begin
         bad++; $display("FAIL single_arready got=%0b%0b exp=10", m0_arready, m1_arready);
      end
      tick();
      s_arready = 1'b0; m0_arvalid = 1'b0;
      s_rvalid = 1'b1; s_rdata = 64'h11; s_rlast = 1'b0; s_rresp = 2'b10;
      #1;
      total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 64'h11 || m0_rresp !== 2'b10) begin
         bad++; $display("FAIL single_beat1 got=%0b/%h/%0d exp=1/11/2", m0_rvalid, m0_rdata, m0_rresp);
      end
      total++; if (m1_rvalid !== 1'b0) begin bad++; $display("FAIL single_m1_rvalid1 got=%0b exp=0", m1_rvalid); end
      tick();
      s_rdata = 64'h22; s_rlast = 1'b1; s_rresp = 2'b00;
      #1;
      total++; if (m0_rvalid !== 1'b1 || m0_rdata !== 64'h22 || m0_rlast !== 1'b1) begin
         bad++; $display("FAIL single_beat2 got=%0b/%h/%0b exp=1/22/1", m0_rvalid, m0_rdata, m0_rlast);
      end
      total++; if (m1_rvalid !== 1'b0) begin bad++; $display("FAIL single_m1_rvalid2 got=%0b exp=0", m1_rvalid); end
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      total++; if (rd_busy !== 1'b0) begin bad++; $display("FAIL single_done_busy got=%0b exp=0", rd_busy); end
      total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL single_slverr_no_proto got=%0b exp=0", proto_err); end
   endtask

   task automatic test_rr_tie();
      logic ok, o0, o1;
      int w;
      do_reset();
      m0_arlen = 8'd0; m1_arlen = 8'd0;
      m0_arvalid = 1'b1; m1_arvalid = 1'b1;
      grant_cycle(1'b1, ok, w, o0, o1);
      total++; if (!ok || w != 1 || o0 !== 1'b0) begin bad++; $display("FAIL rr_first ok=%0b waits=%0d owner=%0b exp=1/1/0", ok, w, o0); end
      grant_cycle(1'b1, ok, w, o0, o1);
      total++; if (!ok || w != 1 || o0 !== 1'b1) begin bad++; $display("FAIL rr_second ok=%0b waits=%0d owner=%0b exp=1/1/1", ok, w, o0); end
      m0_arvalid = 1'b1; m1_arvalid = 1'b1;
      grant_cycle(1'b1, ok, w, o0, o1);
      total++; if (!ok || o0 !== 1'b0) begin bad++; $display("FAIL rr_repeat ok=%0b owner=%0b exp=1/0", ok, o0); end
      grant_cycle(1'b1, ok, w, o0, o1);
      total++; if (!ok || o0 !== 1'b1) begin bad++; $display("FAIL rr_repeat_m1 ok=%0b owner=%0b exp=1/1", ok, o0); end
   endtask

   task automatic test_fixed_priority();
      logic ok, o0, o1;
      int w;
      do_reset();
      m0_arvalid = 1'b1; m1_arvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         grant_cycle(1'b0, ok, w, o0, o1);
         total++; if (!ok || o1 !== 1'b1) begin bad++; $display("FAIL fixed_tie_%0d ok=%0b owner=%0b exp=1/1", i, ok, o1); end
      end
      m0_arvalid = 1'b0; m1_arvalid = 1'b0;
      tick();
   endtask

   task automatic test_write_block();
      do_reset();
      m1_awaddr = 32'h0000_2000; m1_awlen = 8'd0; m1_awburst = 2'd1;
      m1_awvalid = 1'b1; s_awready = 1'b1;
      m1_wdata = 64'hDEAD_BEEF; m1_wstrb = 8'hFF; m1_wlast = 1'b1; m1_wvalid = 1'b1; s_wready = 1'b1;
      #1;
      total++; if (s_awvalid !== 1'b1 || m1_awready !== 1'b1 || s_awaddr !== 32'h0000_2000) begin
         bad++; $display("FAIL wr_aw_pass got=%0b/%0b/%h exp=1/1/00002000", s_awvalid, m1_awready, s_awaddr);
      end
      total++; if (s_wdata !== 64'hDEAD_BEEF || s_wvalid !== 1'b1 || m1_wready !== 1'b1) begin
         bad++; $display("FAIL wr_w_pass got=%h/%0b/%0b exp=deadbeef/1/1", s_wdata, s_wvalid, m1_wready);
      end
      tick();
      m1_awvalid = 1'b0; s_awready = 1'b0; m1_wvalid = 1'b0; s_wready = 1'b0;
      m1_arvalid = 1'b1; m1_araddr = 32'h0000_3000; m1_arlen = 8'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (m1_arready !== 1'b0 || s_arvalid !== 1'b0) begin
            bad++; $display("FAIL wr_block_%0d got=%0b/%0b exp=0/0", i, m1_arready, s_arvalid);
         end
         tick();
      end
      s_bvalid = 1'b1; s_bresp = 2'b00; m1_bready = 1'b1;
      #1;
      total++; if (m1_bvalid !== 1'b1 || s_bready !== 1'b1 || s_arvalid !== 1'b0) begin
         bad++; $display("FAIL wr_b_pass got=%0b/%0b/%0b exp=1/1/0", m1_bvalid, s_bready, s_arvalid);
      end
      tick();
      s_bvalid = 1'b0; m1_bready = 1'b0;
      m1_awvalid = 1'b1; s_awready = 1'b1;
      #1;
      total++; if (s_awvalid !== 1'b0 || m1_awready !== 1'b0 || s_arvalid !== 1'b0) begin
         bad++; $display("FAIL wr_simul_mask got=%0b/%0b/%0b exp=0/0/0", s_awvalid, m1_awready, s_arvalid);
      end
      tick();
      total++; if (s_arvalid !== 1'b1 || rd_owner !== 1'b1 || s_araddr !== 32'h0000_3000) begin
         bad++; $display("FAIL wr_grant_after_b got=%0b/%0b/%h exp=1/1/00003000", s_arvalid, rd_owner, s_araddr);
      end
      total++; if (s_awvalid !== 1'b0 || m1_awready !== 1'b0) begin
         bad++; $display("FAIL wr_aw_mask_rd got=%0b/%0b exp=0/0", s_awvalid, m1_awready);
      end
      s_arready = 1'b1;
      #1;
      total++; if (m1_arready !== 1'b1) begin bad++; $display("FAIL wr_m1_arready got=%0b exp=1", m1_arready); end
      tick();
      s_arready = 1'b0; m1_arvalid = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'h44;
      #1;
      total++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 64'h44) begin
         bad++; $display("FAIL wr_m1_beat got=%0b/%0b/%h exp=1/0/44", m1_rvalid, m0_rvalid, m1_rdata);
      end
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      #1;
      total++; if (rd_busy !== 1'b0 || s_awvalid !== 1'b1) begin
         bad++; $display("FAIL wr_aw_unmask got=%0b/%0b exp=0/1", rd_busy, s_awvalid);
      end
      m1_awvalid = 1'b0; s_awready = 1'b0;
   endtask

   task automatic test_proto_err();
      logic ok, o0, o1;
      int w;
      do_reset();
      m0_araddr = 32'h0000_4000; m0_arlen = 8'd3; m0_arvalid = 1'b1;
      tick();
      total++; if (s_arvalid !== 1'b1 || s_arlen !== 8'd3) begin
         bad++; $display("FAIL perr_ar got=%0b/%0d exp=1/3", s_arvalid, s_arlen);
      end
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0; m0_arvalid = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'h33;
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0;
      total++; if (proto_err !== 1'b1 || rd_busy !== 1'b0) begin
         bad++; $display("FAIL perr_set got=%0b/%0b exp=1/0", proto_err, rd_busy);
      end
      m0_arlen = 8'd0; m0_arvalid = 1'b1;
      grant_cycle(1'b1, ok, w, o0, o1);
      total++; if (!ok || proto_err !== 1'b1) begin bad++; $display("FAIL perr_sticky ok=%0b got=%0b exp=1/1", ok, proto_err); end
   endtask

   task automatic test_reset_mid_burst();
      logic ok, o0, o1;
      int w;
      m0_arlen = 8'd1; m0_arvalid = 1'b1;
      tick();
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0; m0_arvalid = 1'b0;
      s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 64'h55;
      #1;
      total++; if (rd_busy !== 1'b1 || s_rready !== 1'b1) begin
         bad++; $display("FAIL rstmid_pre got=%0b/%0b exp=1/1", rd_busy, s_rready);
      end
      #1;
      rst_n = 1'b0;
      #1;
      total++; if ({rd_busy, s_arvalid, s_rready, m0_rvalid, proto_err} !== 5'b0) begin
         bad++; $display("FAIL rstmid_async got=%b exp=00000", {rd_busy, s_arvalid, s_rready, m0_rvalid, proto_err});
      end
      s_rvalid = 1'b0;
      tick();
      rst_n = 1'b1;
      m0_arlen = 8'd0; m0_arvalid = 1'b1;
      grant_cycle(1'b1, ok, w, o0, o1);
      total++; if (!ok || w != 1 || o0 !== 1'b0) begin bad++; $display("FAIL rstmid_after ok=%0b waits=%0d owner=%0b exp=1/1/0", ok, w, o0); end
      total++; if (proto_err !== 1'b0 || rd_busy !== 1'b0) begin
         bad++; $display("FAIL rstmid_clean got=%0b/%0b exp=0/0", proto_err, rd_busy);
      end
   endtask

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0;
      m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0; m0_arvalid = 1'b0;
      m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0; m1_arvalid = 1'b0;
      m0_rready = 1'b1; m1_rready = 1'b1;
      m1_awaddr = '0; m1_awlen = '0; m1_awburst = '0; m1_awvalid = 1'b0;
      m1_wdata = '0; m1_wstrb = '0; m1_wlast = 1'b0; m1_wvalid = 1'b0; m1_bready = 1'b0;
      s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
      s_awready = 1'b0; s_wready = 1'b0; s_bresp = '0; s_bvalid = 1'b0;
      test_reset();
      test_m0_single();
      test_rr_tie();
      test_fixed_priority();
      test_write_block();
      test_proto_err();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
